// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] RESULT_RST = '0;

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// One-bit full adder used as the bit-slice of the serial subtractor.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry_in,
  output logic o_s,
  output logic o_carry_out
);

  assign o_s         = i_a ^ i_b ^ i_carry_in;
  assign o_carry_out = (i_a & i_b) | (i_carry_in & (i_a ^ i_b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a + ~b + 1, one bit per clock, LSB first.
//   state | meaning
//   IDLE  | o_ready high, waiting for i_start
//   RUN   | one result bit per edge, WIDTH edges
//   DONE  | o_done pulse, results registered
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  full_adder u_fa (
    .i_a        (r_sh_a[0]),
    .i_b        (r_sh_b[0]),
    .i_carry_in (r_carry),
    .o_s        (w_sum),
    .o_carry_out(w_cout)
  );

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_res      <= RESULT_RST[WIDTH-1:0];
      r_carry    <= 1'b0;
      r_diff     <= RESULT_RST[WIDTH-1:0];
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_sh_a  <= i_a;
            r_sh_b  <= ~i_b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sh_a  <= r_sh_a >> 1;
          r_sh_b  <= r_sh_b >> 1;
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
          if (w_last) begin
            // On the MSB edge r_carry is still the MSB stage's carry-in.
            r_diff     <= {w_sum, r_res[WIDTH-1:1]};
            r_borrow   <= ~w_cout;
            r_overflow <= r_carry ^ w_cout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (r_state == IDLE);
  assign o_done     = (r_state == DONE);
  assign o_diff     = r_diff;
  assign o_borrow   = r_borrow;
  assign o_overflow = r_overflow;

endmodule
